// File: rtl/cache_mem_responder.sv
// cache_mem_responder: arbitrates per-port dcache read-fill / write-back
// requests onto NUM_CHANNELS memory channels and relays responses back with a
// hold-until-release handshake.
// Optional build macro CACHE_MEM_RESPONDER_WRITE_FIRST_EN: when defined, the
// idle scan grants write-backs from any port ahead of all read fills.
module cache_mem_responder #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CONSUMERS-1:0]                     req_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]      req_read_address,
  output logic [NUM_CONSUMERS-1:0]                     req_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]      req_read_data,
  input  logic [NUM_CONSUMERS-1:0]                     req_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]      req_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]      req_write_data,
  output logic [NUM_CONSUMERS-1:0]                     req_write_ready,
  output logic [NUM_CHANNELS-1:0]                      mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]       mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                      mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]       mem_read_data,
  output logic [NUM_CHANNELS-1:0]                      mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]       mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]       mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                      mem_write_ready
);

  localparam int unsigned PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state [NUM_CHANNELS];
  logic [PW-1:0]            owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] serving;
  logic [PW-1:0]            rr_ptr;

  logic [NUM_CHANNELS-1:0]  grant_c;
  logic [NUM_CHANNELS-1:0]  grant_wr_c;
  logic [PW-1:0]            grant_port_c [NUM_CHANNELS];
  logic [PW-1:0]            ptr_next_c;

  // Round-robin grant scan: channels in ascending order, each hiding its pick from the rest
  always_comb begin : grant_scan
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic                     any;
    logic [PW-1:0]            pi;
    int                       s;
    int                       last_off;
    taken    = serving;
    any      = 1'b0;
    last_off = 0;
    found    = 1'b0;
    pi       = '0;
    s        = 0;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      grant_c[c]      = 1'b0;
      grant_wr_c[c]   = 1'b0;
      grant_port_c[c] = '0;
      found           = 1'b0;
      if (state[c] == IDLE) begin
`ifdef CACHE_MEM_RESPONDER_WRITE_FIRST_EN
        for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
          s = int'(rr_ptr) + i;
          if (s >= int'(NUM_CONSUMERS)) s = s - int'(NUM_CONSUMERS);
          pi = PW'(s);
          if (!found && !taken[pi] && req_write_valid[pi]) begin
            found = 1'b1; grant_c[c] = 1'b1; grant_wr_c[c] = 1'b1;
            grant_port_c[c] = pi; taken[pi] = 1'b1; any = 1'b1;
            if (i > last_off) last_off = i;
          end
        end
        for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
          s = int'(rr_ptr) + i;
          if (s >= int'(NUM_CONSUMERS)) s = s - int'(NUM_CONSUMERS);
          pi = PW'(s);
          if (!found && !taken[pi] && req_read_valid[pi]) begin
            found = 1'b1; grant_c[c] = 1'b1; grant_wr_c[c] = 1'b0;
            grant_port_c[c] = pi; taken[pi] = 1'b1; any = 1'b1;
            if (i > last_off) last_off = i;
          end
        end
`else
        for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
          s = int'(rr_ptr) + i;
          if (s >= int'(NUM_CONSUMERS)) s = s - int'(NUM_CONSUMERS);
          pi = PW'(s);
          if (!found && !taken[pi] && (req_write_valid[pi] || req_read_valid[pi])) begin
            found = 1'b1; grant_c[c] = 1'b1; grant_wr_c[c] = req_write_valid[pi];
            grant_port_c[c] = pi; taken[pi] = 1'b1; any = 1'b1;
            if (i > last_off) last_off = i;
          end
        end
`endif
      end
    end
    s = int'(rr_ptr) + last_off + 1;
    if (s >= int'(NUM_CONSUMERS)) s = s - int'(NUM_CONSUMERS);
    ptr_next_c = any ? PW'(s) : rr_ptr;
  end

  // Per-channel FSMs, serving mask, pointer and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      req_read_ready    <= '0;
      req_read_data     <= '0;
      req_write_ready   <= '0;
      mem_read_valid    <= '0;
      mem_read_address  <= '0;
      mem_write_valid   <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      serving           <= '0;
      rr_ptr            <= '0;
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        state[c] <= IDLE;
        owner[c] <= '0;
      end
    end else begin
      rr_ptr <= ptr_next_c;
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        case (state[c])
          IDLE: begin
            if (grant_c[c]) begin
              owner[c]                 <= grant_port_c[c];
              serving[grant_port_c[c]] <= 1'b1;
              if (grant_wr_c[c]) begin
                mem_write_valid[c]   <= 1'b1;
                mem_write_address[c] <= req_write_address[grant_port_c[c]];
                mem_write_data[c]    <= req_write_data[grant_port_c[c]];
                state[c]             <= WRITE_WAITING;
              end else begin
                mem_read_valid[c]    <= 1'b1;
                mem_read_address[c]  <= req_read_address[grant_port_c[c]];
                state[c]             <= READ_WAITING;
              end
            end
          end
          READ_WAITING: begin
            if (mem_read_ready[c]) begin
              mem_read_valid[c]       <= 1'b0;
              req_read_data[owner[c]] <= mem_read_data[c];
              req_read_ready[owner[c]] <= 1'b1;
              state[c]                <= READ_RELAYING;
            end
          end
          WRITE_WAITING: begin
            if (mem_write_ready[c]) begin
              mem_write_valid[c]        <= 1'b0;
              req_write_ready[owner[c]] <= 1'b1;
              state[c]                  <= WRITE_RELAYING;
            end
          end
          READ_RELAYING: begin
            if (!req_read_valid[owner[c]]) begin
              req_read_ready[owner[c]] <= 1'b0;
              serving[owner[c]]        <= 1'b0;
              state[c]                 <= IDLE;
            end
          end
          WRITE_RELAYING: begin
            if (!req_write_valid[owner[c]]) begin
              req_write_ready[owner[c]] <= 1'b0;
              serving[owner[c]]         <= 1'b0;
              state[c]                  <= IDLE;
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed testbench for cache_mem_responder (default parameters).
module tb_cache_mem_responder;

  logic                 clk;
  logic                 reset;
  logic [7:0]           req_read_valid;
  logic [7:0][7:0]      req_read_address;
  logic [7:0]           req_read_ready;
  logic [7:0][7:0]      req_read_data;
  logic [7:0]           req_write_valid;
  logic [7:0][7:0]      req_write_address;
  logic [7:0][7:0]      req_write_data;
  logic [7:0]           req_write_ready;
  logic [3:0]           mem_read_valid;
  logic [3:0][7:0]      mem_read_address;
  logic [3:0]           mem_read_ready;
  logic [3:0][7:0]      mem_read_data;
  logic [3:0]           mem_write_valid;
  logic [3:0][7:0]      mem_write_address;
  logic [3:0][7:0]      mem_write_data;
  logic [3:0]           mem_write_ready;

  int tests_run;
  int tests_failed;

  cache_mem_responder dut (
    .clk(clk), .reset(reset),
    .req_read_valid(req_read_valid), .req_read_address(req_read_address),
    .req_read_ready(req_read_ready), .req_read_data(req_read_data),
    .req_write_valid(req_write_valid), .req_write_address(req_write_address),
    .req_write_data(req_write_data), .req_write_ready(req_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so registered outputs can be sampled and inputs changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_read_valid = '0; req_read_address = '0;
    req_write_valid = '0; req_write_address = '0; req_write_data = '0;
    mem_read_ready = '0; mem_read_data = '0;
    mem_write_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    check("rst_mem_rd_valid", 32'(mem_read_valid), 32'h0);
    check("rst_mem_wr_valid", 32'(mem_write_valid), 32'h0);
    check("rst_req_rd_ready", 32'(req_read_ready), 32'h0);
    check("rst_req_wr_ready", 32'(req_write_ready), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_no_strobe", 32'({mem_read_valid, mem_write_valid}), 32'h0);

    // Single read, port 2, two memory wait cycles
    req_read_valid[2] = 1'b1; req_read_address[2] = 8'h3C;
    tick();
    check("rd_mem_valid", 32'(mem_read_valid), 32'h1);
    check("rd_mem_addr", 32'(mem_read_address[0]), 32'h3C);
    tick();
    check("rd_wait1_valid", 32'(mem_read_valid), 32'h1);
    tick();
    check("rd_wait2_addr", 32'(mem_read_address[0]), 32'h3C);
    check("rd_wait2_ready", 32'(req_read_ready), 32'h0);
    mem_read_ready[0] = 1'b1; mem_read_data[0] = 8'hA5;
    tick();
    mem_read_ready[0] = 1'b0;
    check("rd_req_ready", 32'(req_read_ready), 32'h04);
    check("rd_req_data", 32'(req_read_data[2]), 32'hA5);
    check("rd_mem_valid_clr", 32'(mem_read_valid), 32'h0);
    tick();
    check("rd_ready_held", 32'(req_read_ready), 32'h04);
    req_read_valid[2] = 1'b0;
    tick();
    check("rd_ready_release", 32'(req_read_ready), 32'h0);

    // Single write, port 0 (pointer is 3 here, channel 0 free again)
    req_write_valid[0] = 1'b1; req_write_address[0] = 8'h10; req_write_data[0] = 8'h7E;
    tick();
    check("wr_mem_valid", 32'(mem_write_valid), 32'h1);
    check("wr_mem_addr", 32'(mem_write_address[0]), 32'h10);
    check("wr_mem_data", 32'(mem_write_data[0]), 32'h7E);
    check("wr_no_rd", 32'(mem_read_valid), 32'h0);
    mem_write_ready[0] = 1'b1;
    tick();
    mem_write_ready[0] = 1'b0;
    check("wr_req_ready", 32'(req_write_ready), 32'h01);
    check("wr_mem_valid_clr", 32'(mem_write_valid), 32'h0);
    req_write_valid[0] = 1'b0;
    tick();
    check("wr_ready_release", 32'(req_write_ready), 32'h0);

    // Contention: all eight ports read from pointer 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_read_valid[i] = 1'b1;
      req_read_address[i] = 8'(8'h40 + i);
    end
    tick();
    check("ct_valid_r1", 32'(mem_read_valid), 32'hF);
    check("ct_addr_r1", {mem_read_address[3], mem_read_address[2], mem_read_address[1], mem_read_address[0]}, 32'h43424140);
    mem_read_ready[1] = 1'b1; mem_read_data[1] = 8'h91;
    tick();
    mem_read_ready[1] = 1'b0;
    check("ct_ready_p1", 32'(req_read_ready), 32'h02);
    check("ct_data_p1", 32'(req_read_data[1]), 32'h91);
    check("ct_valid_ch1_off", 32'(mem_read_valid), 32'hD);
    req_read_valid[1] = 1'b0;
    tick();
    check("ct_release_p1", 32'(req_read_ready), 32'h0);
    check("ct_ch1_idle", 32'(mem_read_valid), 32'hD);
    tick();
    check("ct_regrant_valid", 32'(mem_read_valid), 32'hF);
    check("ct_regrant_p4", 32'(mem_read_address[1]), 32'h44);
    mem_read_ready = 4'hF;
    mem_read_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    tick();
    mem_read_ready = '0;
    check("ct_ready_r2", 32'(req_read_ready), 32'h1D);
    check("ct_data_p4", 32'(req_read_data[4]), 32'hC1);
    check("ct_data_p3", 32'(req_read_data[3]), 32'hC3);
    req_read_valid[0] = 1'b0; req_read_valid[2] = 1'b0;
    req_read_valid[3] = 1'b0; req_read_valid[4] = 1'b0;
    tick();
    tick();
    check("ct_valid_r3", 32'(mem_read_valid), 32'h7);
    check("ct_addr_r3", {8'h0, mem_read_address[2], mem_read_address[1], mem_read_address[0]}, 32'h00474645);
    mem_read_ready = 4'h7;
    tick();
    mem_read_ready = '0;
    check("ct_ready_r3", 32'(req_read_ready), 32'hE0);
    req_read_valid = '0;
    tick(); tick();
    check("ct_all_idle", 32'({mem_read_valid, req_read_ready}), 32'h0);

    // Port 5 with both valids: write first, read only after write release
    req_write_valid[5] = 1'b1; req_write_address[5] = 8'h20; req_write_data[5] = 8'h55;
    req_read_valid[5] = 1'b1; req_read_address[5] = 8'h21;
    tick();
    check("bv_wr_valid", 32'(mem_write_valid), 32'h1);
    check("bv_wr_addr", 32'(mem_write_address[0]), 32'h20);
    check("bv_no_rd", 32'(mem_read_valid), 32'h0);
    mem_write_ready[0] = 1'b1;
    tick();
    mem_write_ready[0] = 1'b0;
    check("bv_wr_ready", 32'(req_write_ready), 32'h20);
    check("bv_no_rd2", 32'(mem_read_valid), 32'h0);
    req_write_valid[5] = 1'b0;
    tick();
    check("bv_wr_release", 32'({mem_read_valid, req_write_ready}), 32'h0);
    tick();
    check("bv_rd_valid", 32'(mem_read_valid), 32'h1);
    check("bv_rd_addr", 32'(mem_read_address[0]), 32'h21);
    mem_read_ready[0] = 1'b1; mem_read_data[0] = 8'h3D;
    tick();
    mem_read_ready[0] = 1'b0;
    check("bv_rd_ready", 32'(req_read_ready), 32'h20);
    check("bv_rd_data", 32'(req_read_data[5]), 32'h3D);
    req_read_valid[5] = 1'b0;
    tick();

    // Write priority: three channels busy, pointer returns to 0, then port 1 read vs port 6 write
    do_reset();
    req_read_valid[3] = 1'b1; req_read_address[3] = 8'h33;
    req_read_valid[4] = 1'b1; req_read_address[4] = 8'h34;
    req_read_valid[7] = 1'b1; req_read_address[7] = 8'h37;
    tick();
    check("wp_busy3", 32'(mem_read_valid), 32'h7);
    req_read_valid[1] = 1'b1; req_read_address[1] = 8'h11;
    req_write_valid[6] = 1'b1; req_write_address[6] = 8'h66; req_write_data[6] = 8'h06;
    tick();
`ifdef CACHE_MEM_RESPONDER_WRITE_FIRST_EN
    check("wp_rd_valid", 32'(mem_read_valid), 32'h7);
    check("wp_wr_valid", 32'(mem_write_valid), 32'h8);
    check("wp_wr_addr", 32'(mem_write_address[3]), 32'h66);
`else
    check("wp_rd_valid", 32'(mem_read_valid), 32'hF);
    check("wp_wr_valid", 32'(mem_write_valid), 32'h0);
    check("wp_rd_addr", 32'(mem_read_address[3]), 32'h11);
`endif

    // Reset while channels sit in READ_WAITING
    reset = 1'b1;
    tick();
    check("rw_mem_strobes", 32'({mem_read_valid, mem_write_valid}), 32'h0);
    check("rw_req_ready", 32'({req_read_ready, req_write_ready}), 32'h0);
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();
    check("rw_idle_after", 32'({mem_read_valid, mem_write_valid}), 32'h0);
    req_read_valid[1] = 1'b1; req_read_address[1] = 8'h77;
    req_read_valid[7] = 1'b1; req_read_address[7] = 8'h78;
    tick();
    check("rw_fresh_valid", 32'(mem_read_valid), 32'h3);
    check("rw_fresh_addr", 32'({mem_read_address[1], mem_read_address[0]}), 32'h7877);
    mem_read_ready = 4'h3;
    mem_read_data = {8'h00, 8'h00, 8'hE7, 8'hE1};
    tick();
    mem_read_ready = '0;
    check("rw_fresh_ready", 32'(req_read_ready), 32'h82);
    check("rw_fresh_data", 32'({req_read_data[7], req_read_data[1]}), 32'hE7E1);
    req_read_valid = '0;
    tick();
    check("rw_fresh_release", 32'(req_read_ready), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
